// File: rtl/keccak_pad_stream.sv
// Byte-stream Keccak multi-rate padder: packs message bytes into rate-sized blocks,
// appends the domain-separation byte and the final 0x80 bit, and hands blocks to an absorber.
module keccak_pad_stream #(
    parameter int         RATE_BITS = 1088,
    parameter logic [7:0] DS_BYTE   = 8'h1F
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pad_start,
    input  logic                 in_valid,
    input  logic                 in_keep,
    input  logic [7:0]           in_byte,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [RATE_BITS-1:0] block,
    output logic                 block_valid,
    output logic                 block_last,
    input  logic                 block_ready,
    output logic                 pad_done,
    output logic [2:0]           debug_pad_state,
    output logic [15:0]          debug_block_count
);

    localparam int R     = RATE_BITS / 8;
    localparam int PTR_W = $clog2(R + 1);

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(R);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_PAD   = 3'd2,
        S_EMIT  = 3'd3,
        S_EXTRA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [RATE_BITS-1:0]   blk_q, blk_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       ptr_inc;
    logic                   extra_q, extra_d;
    logic                   last_q, last_d;
    logic [15:0]            count_q, count_d;
    logic                   in_ready_q, in_ready_d;
    logic                   valid_q, valid_d;
    logic                   pad_done_q, pad_done_d;
    logic [R-1:0]           ptr_hot;

    // One-hot decode of the byte pointer keeps every buffer write at a constant index.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_ptr_hot
            assign ptr_hot[gi] = (ptr_q == PTR_W'(gi));
        end
    endgenerate

    assign ptr_inc = ptr_q + PTR_ONE;

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        ptr_d   = ptr_q;
        extra_d = extra_q;
        last_d  = last_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (pad_start) begin
                    blk_d   = '0;
                    ptr_d   = '0;
                    count_d = '0;
                    extra_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_FILL;
                end
            end

            S_FILL: begin
                if (in_valid) begin
                    if (in_keep) begin
                        for (int i = 0; i < R; i++) begin
                            if (ptr_hot[i]) begin
                                blk_d[8*i +: 8] = in_byte;
                            end
                        end
                        ptr_d = ptr_inc;
                    end
                    if (in_last) begin
                        state_d = S_PAD;
                    end else if (in_keep && (ptr_inc == PTR_FULL)) begin
                        last_d  = 1'b0;
                        state_d = S_EMIT;
                    end
                end
            end

            S_PAD: begin
                if (ptr_q != PTR_FULL) begin
                    // Applied in sequence so a pointer at R-1 yields DS_BYTE ^ 0x80.
                    for (int i = 0; i < R; i++) begin
                        if (ptr_hot[i]) begin
                            blk_d[8*i +: 8] = blk_d[8*i +: 8] ^ DS_BYTE;
                        end
                    end
                    blk_d[RATE_BITS-1 -: 8] = blk_d[RATE_BITS-1 -: 8] ^ 8'h80;
                    last_d = 1'b1;
                end else begin
                    extra_d = 1'b1;
                    last_d  = 1'b0;
                end
                state_d = S_EMIT;
            end

            S_EMIT: begin
                if (block_ready) begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (extra_q) begin
                        state_d = S_EXTRA;
                    end else begin
                        blk_d   = '0;
                        ptr_d   = '0;
                        state_d = S_FILL;
                    end
                end
            end

            S_EXTRA: begin
                blk_d                   = '0;
                blk_d[7:0]              = DS_BYTE;
                blk_d[RATE_BITS-1 -: 8] = 8'h80;
                extra_d                 = 1'b0;
                last_d                  = 1'b1;
                state_d                 = S_EMIT;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they align with state_q.
    always_comb begin
        in_ready_d = (state_d == S_FILL);
        valid_d    = (state_d == S_EMIT);
        pad_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            blk_q      <= '0;
            ptr_q      <= '0;
            extra_q    <= 1'b0;
            last_q     <= 1'b0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            pad_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            ptr_q      <= ptr_d;
            extra_q    <= extra_d;
            last_q     <= last_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            valid_q    <= valid_d;
            pad_done_q <= pad_done_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign block             = blk_q;
    assign block_valid       = valid_q;
    assign block_last        = last_q;
    assign pad_done          = pad_done_q;
    assign debug_pad_state   = state_q;
    assign debug_block_count = count_q;

endmodule
